// File: rtl/write_data_order_mux.sv
// Slave-side W-channel mux: forwards whole bursts from NUM_SRC per-ID streams
// in the order their AW transactions were granted, with one registered output stage.
//
// state  | meaning
// IDLE   | order queue empty, nothing to forward
// SELECT | searching the sources for the head wid (lowest index wins)
// STREAM | forwarding the locked source's burst until its wlast
module write_data_order_mux #(
  parameter int NUM_SRC     = 3,
  parameter int ORDER_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [5:0]                       s_aw_order_id,
  input  logic                             s_aw_order_valid,
  output logic                             s_aw_order_ready,
  input  logic [NUM_SRC*6-1:0]             s_w_wid,
  input  logic [NUM_SRC*32-1:0]            s_w_wdata,
  input  logic [NUM_SRC*4-1:0]             s_w_wstrb,
  input  logic [NUM_SRC-1:0]               s_w_wlast,
  input  logic [NUM_SRC-1:0]               s_w_valid,
  output logic [NUM_SRC-1:0]               s_w_ready,
  output logic [5:0]                       m_axi_w_wid,
  output logic [31:0]                      m_axi_w_wdata,
  output logic [3:0]                       m_axi_w_wstrb,
  output logic                             m_axi_w_wlast,
  output logic                             m_axi_w_valid,
  input  logic                             m_axi_w_ready,
  output logic [$clog2(ORDER_DEPTH):0]     order_count
);

  localparam int PW = $clog2(ORDER_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {IDLE, SELECT, STREAM} state_t;

  state_t        state, state_nxt;
  logic [5:0]    order_mem [ORDER_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          full, empty, push, pop;
  logic [5:0]    head_wid;

  logic [SW-1:0] sel, sel_cur, found_idx;
  logic          found, match, accept;
  logic [5:0]    cur_wid;
  logic [31:0]   cur_data;
  logic [3:0]    cur_strb;
  logic          cur_last, cur_valid;

  assign full             = (count == CW'(ORDER_DEPTH));
  assign empty            = (count == '0);
  assign head_wid         = order_mem[rd_ptr];
  assign push             = s_aw_order_valid && !full;
  assign pop              = accept && cur_last;
  assign count_nxt        = count + CW'(push) - CW'(pop);
  assign s_aw_order_ready = !full;
  assign order_count      = count;

  // Lowest-index valid source whose wid matches the queue head.
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (s_w_valid[k] && (s_w_wid[6*k +: 6] == head_wid)) begin
        found     = 1'b1;
        found_idx = SW'(k);
      end
    end
  end

  assign sel_cur = (state == SELECT) ? found_idx : sel;

  always_comb begin
    cur_wid   = '0;
    cur_data  = '0;
    cur_strb  = '0;
    cur_last  = 1'b0;
    cur_valid = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel_cur == SW'(k)) begin
        cur_wid   = s_w_wid[6*k +: 6];
        cur_data  = s_w_wdata[32*k +: 32];
        cur_strb  = s_w_wstrb[4*k +: 4];
        cur_last  = s_w_wlast[k];
        cur_valid = s_w_valid[k];
      end
    end
  end

  always_comb begin
    match = 1'b0;
    case (state)
      SELECT:  match = found;
      STREAM:  match = cur_valid && (cur_wid == head_wid);
      default: match = 1'b0;
    endcase
  end

  assign accept = match && (!m_axi_w_valid || m_axi_w_ready);

  always_comb begin
    s_w_ready = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      s_w_ready[k] = accept && (sel_cur == SW'(k));
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!empty) state_nxt = SELECT;
      end
      SELECT: begin
        if (pop)        state_nxt = (count_nxt != '0) ? SELECT : IDLE;
        else if (found) state_nxt = STREAM;
      end
      STREAM: begin
        if (pop) state_nxt = (count_nxt != '0) ? SELECT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (state == SELECT && found) sel <= found_idx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Payload storage carries no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (push) order_mem[wr_ptr] <= s_aw_order_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axi_w_wid   <= '0;
      m_axi_w_wdata <= '0;
      m_axi_w_wstrb <= '0;
      m_axi_w_wlast <= 1'b0;
      m_axi_w_valid <= 1'b0;
    end else if (accept) begin
      m_axi_w_wid   <= cur_wid;
      m_axi_w_wdata <= cur_data;
      m_axi_w_wstrb <= cur_strb;
      m_axi_w_wlast <= cur_last;
      m_axi_w_valid <= 1'b1;
    end else if (m_axi_w_ready) begin
      m_axi_w_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_write_data_order_mux.sv
// Bench for write_data_order_mux: per-source burst queues feed the DUT and a
// queue-level order model predicts the exact output beat sequence.
module tb_write_data_order_mux;
  localparam int NS = 3;
  localparam int D  = 4;

  typedef struct packed {
    logic [5:0]  wid;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [5:0] s_aw_order_id;
  logic s_aw_order_valid, s_aw_order_ready;
  logic [NS*6-1:0] s_w_wid;
  logic [NS*32-1:0] s_w_wdata;
  logic [NS*4-1:0] s_w_wstrb;
  logic [NS-1:0] s_w_wlast, s_w_valid, s_w_ready;
  logic [5:0] m_axi_w_wid;
  logic [31:0] m_axi_w_wdata;
  logic [3:0] m_axi_w_wstrb;
  logic m_axi_w_wlast, m_axi_w_valid, m_axi_w_ready;
  logic [2:0] order_count;

  always #5 clk = ~clk;

  write_data_order_mux #(.NUM_SRC(NS), .ORDER_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_aw_order_id(s_aw_order_id), .s_aw_order_valid(s_aw_order_valid),
    .s_aw_order_ready(s_aw_order_ready),
    .s_w_wid(s_w_wid), .s_w_wdata(s_w_wdata), .s_w_wstrb(s_w_wstrb),
    .s_w_wlast(s_w_wlast), .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
    .m_axi_w_wid(m_axi_w_wid), .m_axi_w_wdata(m_axi_w_wdata),
    .m_axi_w_wstrb(m_axi_w_wstrb), .m_axi_w_wlast(m_axi_w_wlast),
    .m_axi_w_valid(m_axi_w_valid), .m_axi_w_ready(m_axi_w_ready),
    .order_count(order_count)
  );

  beat_t      src_q [NS][$];
  logic [5:0] order_list[$];
  logic [5:0] aw_pend[$];
  beat_t      exp_q[$];
  logic       rdy_seq[$];
  int         rdy_pct = 100;
  int         vectors = 0;
  int         miss = 0;
  logic       prev_stall, prev_fire;
  logic [42:0] prev_out;
  beat_t      fired_beat;
  logic [5:0] pool [4] = '{6'h05, 6'h12, 6'h21, 6'h33};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: each order takes the whole front burst of the lowest-index
  // source whose front burst carries that wid.
  function automatic bit model_run();
    beat_t sq [NS][$];
    beat_t b;
    int    pick;
    exp_q.delete();
    for (int k = 0; k < NS; k++) sq[k] = src_q[k];
    foreach (order_list[i]) begin
      pick = -1;
      for (int k = NS - 1; k >= 0; k--)
        if (sq[k].size() > 0 && sq[k][0].wid == order_list[i]) pick = k;
      if (pick < 0) return 1'b0;
      do begin
        b = sq[pick].pop_front();
        exp_q.push_back(b);
      end while (!b.last);
    end
    return 1'b1;
  endfunction

  function automatic bit srcs_busy();
    for (int k = 0; k < NS; k++) if (src_q[k].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_burst(input int s, input logic [5:0] w, input int len, input logic [31:0] base);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.wid  = w;
      b.data = base + 32'(j);
      b.strb = 4'($urandom_range(15));
      b.last = (j == len - 1);
      src_q[s].push_back(b);
    end
  endtask

  task automatic clear_all();
    for (int k = 0; k < NS; k++) src_q[k].delete();
    order_list.delete();
    aw_pend.delete();
    exp_q.delete();
    rdy_seq.delete();
  endtask

  task automatic drive();
    beat_t b;
    s_aw_order_valid = (aw_pend.size() > 0);
    s_aw_order_id    = s_aw_order_valid ? aw_pend[0] : 6'h00;
    for (int k = 0; k < NS; k++) begin
      if (src_q[k].size() > 0) begin
        b = src_q[k][0];
        s_w_valid[k] = 1'b1;
      end else begin
        b = '0;
        s_w_valid[k] = 1'b0;
      end
      s_w_wid[6*k +: 6]    = b.wid;
      s_w_wdata[32*k +: 32] = b.data;
      s_w_wstrb[4*k +: 4]   = b.strb;
      s_w_wlast[k]          = b.last;
    end
    if (rdy_seq.size() > 0) m_axi_w_ready = rdy_seq.pop_front();
    else m_axi_w_ready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic tick();
    logic [NS-1:0] fire;
    logic          awf;
    logic [42:0]   outv;
    @(negedge clk);
    outv = {m_axi_w_wid, m_axi_w_wdata, m_axi_w_wstrb, m_axi_w_wlast};
    check("ready_onehot", 64'($countones(s_w_ready) <= 1), 1);
    if (prev_fire) begin
      check("latency_valid", m_axi_w_valid, 1);
      check("latency_beat", outv, fired_beat);
    end
    if (prev_stall) begin
      check("stall_valid", m_axi_w_valid, 1);
      check("stall_hold", outv, prev_out);
    end
    if (m_axi_w_valid && m_axi_w_ready) begin
      if (exp_q.size() == 0) check("extra_beat", exp_q.size(), 1);
      else begin
        check("beat", outv, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
    fire = s_w_valid & s_w_ready;
    awf  = s_aw_order_valid && s_aw_order_ready;
    prev_fire = 1'b0;
    for (int k = 0; k < NS; k++) if (fire[k]) begin
      prev_fire  = 1'b1;
      fired_beat = src_q[k][0];
    end
    prev_stall = m_axi_w_valid && !m_axi_w_ready;
    prev_out   = outv;
    @(posedge clk);
    #1;
    for (int k = 0; k < NS; k++) if (fire[k]) void'(src_q[k].pop_front());
    if (awf) void'(aw_pend.pop_front());
    drive();
  endtask

  task automatic run_drain(input int max_cyc, output int n);
    n = 0;
    while ((exp_q.size() > 0 || aw_pend.size() > 0 || srcs_busy()) && n < max_cyc) begin
      tick();
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic gen_random(input int nb);
    bit         ok;
    logic [5:0] w;
    int         s, len;
    clear_all();
    for (int i = 0; i < nb; i++) begin
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
        w   = pool[$urandom_range(3)];
        s   = $urandom_range(NS - 1);
        len = $urandom_range(1, 4);
        add_burst(s, w, len, $urandom());
        order_list.push_back(w);
        ok = model_run();
        if (!ok) begin
          void'(order_list.pop_back());
          for (int j = 0; j < len; j++) void'(src_q[s].pop_back());
        end
      end
      if (!ok) begin
        w = 6'h38 + 6'(i);
        add_burst($urandom_range(NS - 1), w, $urandom_range(1, 4), $urandom());
        order_list.push_back(w);
      end
    end
    void'(model_run());
    aw_pend = order_list;
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    prev_stall = 1'b0;
    prev_fire  = 1'b0;
    prev_out   = '0;
    clear_all();
    s_w_valid = '0;
    drive();
    #12;
    check("rst_aw_ready", s_aw_order_ready, 1);
    check("rst_valid", m_axi_w_valid, 0);
    check("rst_count", order_count, 0);
    check("rst_s_ready", s_w_ready, 0);
    check("rst_out", {m_axi_w_wid, m_axi_w_wdata, m_axi_w_wstrb, m_axi_w_wlast}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive();

    // single burst, full throughput
    order_list = '{6'h05};
    aw_pend = order_list;
    drive();
    repeat (3) tick();
    check("t1_count_before", order_count, 1);
    add_burst(1, 6'h05, 4, 32'h10);
    void'(model_run());
    drive();
    run_drain(50, n);
    check("t1_cycles", n, 5);
    check("t1_count_after", order_count, 0);

    // order 0x12 then 0x05, source0 waits behind source2
    clear_all();
    order_list = '{6'h12, 6'h05};
    add_burst(0, 6'h05, 2, 32'h50);
    add_burst(2, 6'h12, 3, 32'h20);
    void'(model_run());
    aw_pend = order_list;
    drive();
    run_drain(100, n);

    // stalled slave during a 3-beat burst
    clear_all();
    order_list = '{6'h0a};
    add_burst(2, 6'h0a, 3, 32'hA0);
    void'(model_run());
    aw_pend = order_list;
    rdy_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    drive();
    run_drain(100, n);

    // queue fill: four orders, fifth refused while full
    clear_all();
    order_list = '{6'h05, 6'h12, 6'h21, 6'h33};
    aw_pend = order_list;
    drive();
    repeat (6) tick();
    check("t4_count_full", order_count, 4);
    check("t4_ready_full", s_aw_order_ready, 0);
    aw_pend.push_back(6'h3c);
    drive();
    repeat (2) tick();
    check("t4_fifth_ignored", order_count, 4);
    aw_pend.delete();
    add_burst(1, 6'h05, 2, 32'h100);
    add_burst(0, 6'h12, 1, 32'h200);
    add_burst(2, 6'h21, 3, 32'h300);
    add_burst(1, 6'h33, 2, 32'h400);
    void'(model_run());
    drive();
    run_drain(200, n);
    check("t4_count_end", order_count, 0);
    check("t4_ready_end", s_aw_order_ready, 1);

    // two sources match the head: lowest index first
    clear_all();
    order_list = '{6'h21, 6'h21};
    add_burst(0, 6'h21, 3, 32'hC0);
    add_burst(2, 6'h21, 2, 32'hD0);
    void'(model_run());
    aw_pend = order_list;
    drive();
    run_drain(100, n);

    // randomized rounds
    for (int r = 0; r < 6; r++) begin
      rdy_pct = $urandom_range(30, 100);
      gen_random(10);
      drive();
      run_drain(2000, n);
    end

    // reset mid-burst
    clear_all();
    rdy_pct = 100;
    order_list = '{6'h30};
    add_burst(1, 6'h30, 4, 32'hE0);
    void'(model_run());
    aw_pend = order_list;
    drive();
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("t6_valid", m_axi_w_valid, 0);
    check("t6_count", order_count, 0);
    check("t6_aw_ready", s_aw_order_ready, 1);
    check("t6_s_ready", s_w_ready, 0);
    clear_all();
    prev_stall = 1'b0;
    prev_fire  = 1'b0;
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    order_list = '{6'h07};
    add_burst(1, 6'h07, 3, 32'hF0);
    void'(model_run());
    aw_pend = order_list;
    drive();
    run_drain(100, n);
    check("t6_count_end", order_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
